// File: rtl/gnss_code_mem_pkg.sv
// Shared configuration for the memory-code generator: channel count, code geometry, default length.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package gnss_code_mem_pkg;

  localparam int GNSS_CHANS    = 12;    // correlator channels, one BRAM bit column each
  localparam int GNSS_CODEBITS = 12;    // chip index width, memory depth 2^CODEBITS
  localparam int GNSS_RD_LAT   = 1;     // must match the BRAM output-register setting
  localparam int GNSS_DEF_LEN  = 4092;  // E1B code length after reset

  // Ceiling log2, usable in parameter and port declarations.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gnss_code_mem_code_hold.sv
// Per-channel chip holder: prefetched next chip, current chip and wrap flag.
// Latency: code_o/epoch_o are combinational on full_chip_i; captures land one clock after cap_i.
// Backpressure: none; full_chip_i is assumed no faster than one prefetch per channel.
module gnss_code_mem_code_hold (
  input  logic clk,
  input  logic rst,
  input  logic cap_i,
  input  logic cap_bit_i,
  input  logic cap_wrap_i,
  input  logic full_chip_i,
  output logic code_o,
  output logic epoch_o
);

  logic next_bit_q;
  logic next_wrap_q;
  logic cur_bit_q;

  // Prefetched chip is captured when the read returns; it becomes current on the chip strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_bit_q  <= 1'b0;
      next_wrap_q <= 1'b0;
      cur_bit_q   <= 1'b0;
    end else begin
      if (cap_i) begin
        next_bit_q  <= cap_bit_i;
        next_wrap_q <= cap_wrap_i;
      end
      if (full_chip_i) cur_bit_q <= next_bit_q;
    end
  end

  // On the strobe the new chip shows immediately instead of waiting for cur_bit_q.
  assign code_o  = full_chip_i ? next_bit_q : cur_bit_q;
  assign epoch_o = full_chip_i & next_wrap_q;

endmodule

// File: rtl/gnss_code_mem.sv
// Memory-code generator: one BRAM column per channel, round-robin prefetch of each channel's next chip.
// Latency: nchip sampled RD_LAT+1 clocks before capture; code_o/epoch_o combinational on full_chip.
// Backpressure: none; each channel may strobe full_chip at most once per CHANS clocks.
module gnss_code_mem
  import gnss_code_mem_pkg::*;
#(
  parameter int CHANS    = GNSS_CHANS,
  parameter int CODEBITS = GNSS_CODEBITS,
  parameter int RD_LAT   = GNSS_RD_LAT,
  parameter int DEF_LEN  = GNSS_DEF_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_start,
  input  logic                      wr,
  input  logic [CHANS-1:0]          wr_data,
  output logic [CODEBITS:0]         wr_cnt,
  input  logic                      len_we,
  input  logic [clog2(CHANS)-1:0]   len_ch,
  input  logic [CODEBITS:0]         len_val,
  input  logic [CHANS*CODEBITS-1:0] nchip_n,
  input  logic [CHANS-1:0]          full_chip,
  output logic [CHANS-1:0]          code_o,
  output logic [CHANS-1:0]          epoch_o,
  output logic [CHANS-1:0]          vld_o
);

  localparam int CHW   = clog2(CHANS);
  localparam int DEPTH = 1 << CODEBITS;
  localparam logic [CODEBITS:0]   CNT_MAX = (CODEBITS+1)'(DEPTH);
  localparam logic [CODEBITS-1:0] DEF_M1  = CODEBITS'(DEF_LEN - 1);

  // Bookkeeping that travels down the read pipe alongside the BRAM word.
  typedef struct packed {
    logic           vld;
    logic           wrap;
    logic [CHW-1:0] ch;
  } rd_tag_t;

  logic [CODEBITS-1:0] waddr_q, waddr_d, wr_addr;
  logic [CODEBITS:0]   wr_cnt_q, wr_cnt_d;
  logic [CODEBITS-1:0] len_m1_q [CHANS];
  logic [CODEBITS-1:0] len_m1_d;
  logic [CHW-1:0]      ch_p_q, ch_p_d;
  int                  rd_k;
  logic [CODEBITS-1:0] rd_nchip, rd_addr;
  logic                rd_wrap;
  rd_tag_t             rd_tag_d;
  rd_tag_t             tag_q [RD_LAT];
  logic [CHANS-1:0]    rd_dat_q [RD_LAT];
  logic [CHANS-1:0]    mem [DEPTH];
  rd_tag_t             ret_tag;
  logic [CHANS-1:0]    ret_dat;
  logic [CHANS-1:0]    cap;
  logic [CHANS-1:0]    vld_q;

  // Write address and word count; ld_start rewinds both and wins over a same-cycle post-increment.
  always_comb begin
    waddr_d  = waddr_q;
    wr_cnt_d = wr_cnt_q;
    if (ld_start) begin
      waddr_d  = {{(CODEBITS-1){1'b0}}, wr};
      wr_cnt_d = {{CODEBITS{1'b0}}, wr};
    end else if (wr) begin
      waddr_d = waddr_q + 1'b1;
      if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  assign wr_addr = ld_start ? '0 : waddr_q;
  assign wr_cnt  = wr_cnt_q;

  // Write-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q  <= '0;
      wr_cnt_q <= '0;
    end else begin
      waddr_q  <= waddr_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Lengths below 2 would make every chip a wrap, so they are clamped to 2.
  assign len_m1_d = (len_val < (CODEBITS+1)'(2)) ? CODEBITS'(1) : CODEBITS'(len_val - 1'b1);

  // Per-channel length-minus-one registers, picked up by that channel's next prefetch.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANS; c++) begin
      if (rst) len_m1_q[c] <= DEF_M1;
      else if (len_we && (len_ch == CHW'(c))) len_m1_q[c] <= len_m1_d;
    end
  end

  assign ch_p_d = (ch_p_q == CHW'(CHANS - 1)) ? '0 : ch_p_q + 1'b1;

  // Round-robin slot counter, parked at 0 while in reset.
  always_ff @(posedge clk) begin
    if (rst) ch_p_q <= '0;
    else     ch_p_q <= ch_p_d;
  end

  // Read the channel whose capture slot is RD_LAT+1 clocks ahead; >= also wraps stale indices.
  always_comb begin
    rd_k = int'(ch_p_q) + RD_LAT + 1;
    if (rd_k >= CHANS) rd_k = rd_k - CHANS;
    rd_nchip = nchip_n[rd_k*CODEBITS +: CODEBITS];
    rd_wrap  = (rd_nchip >= len_m1_q[rd_k]);
    rd_addr  = rd_wrap ? '0 : rd_nchip + 1'b1;
    rd_tag_d = '{vld: 1'b1, wrap: rd_wrap, ch: CHW'(rd_k)};
  end

  // Code BRAM: one write port, a pipelined read port; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_addr] <= wr_data;
    rd_dat_q[0] <= mem[rd_addr];
    for (int i = 1; i < RD_LAT; i++) rd_dat_q[i] <= rd_dat_q[i-1];
  end

  // Tag pipe matches the BRAM latency; reset drops every read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= rd_tag_d;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret_tag = tag_q[RD_LAT-1];
  assign ret_dat = rd_dat_q[RD_LAT-1];

  for (genvar c = 0; c < CHANS; c++) begin : g_ch
    assign cap[c] = ret_tag.vld && (ret_tag.ch == CHW'(c));

    gnss_code_mem_code_hold u_hold (
      .clk        (clk),
      .rst        (rst),
      .cap_i      (cap[c]),
      .cap_bit_i  (ret_dat[c]),
      .cap_wrap_i (ret_tag.wrap),
      .full_chip_i(full_chip[c]),
      .code_o     (code_o[c]),
      .epoch_o    (epoch_o[c])
    );
  end

  // A channel is valid from its first completed prefetch after reset.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_q | cap;
  end

  assign vld_o = vld_q;

endmodule

// File: tb/tb_gnss_code_mem.sv
module tb_gnss_code_mem;
  import gnss_code_mem_pkg::*;

  localparam int CHANS    = 12;
  localparam int CODEBITS = 12;
  localparam int RD_LAT   = 1;
  localparam int DEF_LEN  = 4092;
  localparam int CHW      = clog2(CHANS);
  localparam int DEPTH    = 1 << CODEBITS;
  // Latest strobe offset after a channel's capture slot that still sees an up-to-date prefetch.
  localparam int SAFE_D   = CHANS - RD_LAT - 2;
  localparam int SETTLE   = 2*CHANS + RD_LAT + 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      ld_start = 1'b0;
  logic                      wr = 1'b0;
  logic [CHANS-1:0]          wr_data = '0;
  logic [CODEBITS:0]         wr_cnt;
  logic                      len_we = 1'b0;
  logic [CHW-1:0]            len_ch = '0;
  logic [CODEBITS:0]         len_val = '0;
  logic [CHANS*CODEBITS-1:0] nchip_n = '0;
  logic [CHANS-1:0]          full_chip = '0;
  logic [CHANS-1:0]          code_o;
  logic [CHANS-1:0]          epoch_o;
  logic [CHANS-1:0]          vld_o;

  gnss_code_mem #(
    .CHANS(CHANS), .CODEBITS(CODEBITS), .RD_LAT(RD_LAT), .DEF_LEN(DEF_LEN)
  ) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .wr(wr), .wr_data(wr_data),
    .wr_cnt(wr_cnt), .len_we(len_we), .len_ch(len_ch), .len_val(len_val),
    .nchip_n(nchip_n), .full_chip(full_chip), .code_o(code_o),
    .epoch_o(epoch_o), .vld_o(vld_o)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; cycle 0 is the first clock after the last rst-high edge.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [CHANS-1:0] code_tab [DEPTH];
  int nchip_m [CHANS];
  int len_m   [CHANS];
  int phase_m [CHANS];
  int ep_exp  [CHANS];
  int ep_seen [CHANS];
  int checks = 0;
  int errors = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Column c holds the output stream of a 16-bit LFSR seeded per channel.
  task automatic build_tab();
    logic [15:0] s;
    for (int c = 0; c < CHANS; c++) begin
      s = 16'hACE1 ^ 16'(c*797 + 1);
      if (s == 16'h0) s = 16'h1;
      for (int n = 0; n < DEPTH; n++) begin
        code_tab[n][c] = s[0];
        s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end
    end
  endtask

  task automatic drive_nchip();
    for (int c = 0; c < CHANS; c++) nchip_n[c*CODEBITS +: CODEBITS] = CODEBITS'(nchip_m[c]);
  endtask

  task automatic randomize_channels();
    for (int c = 0; c < CHANS; c++) begin
      nchip_m[c] = $urandom_range(len_m[c] - 1, 0);
      phase_m[c] = $urandom_range(SAFE_D, 0);
    end
  endtask

  task automatic set_len(input int ch, input int val);
    next_cycle();
    len_we = 1'b1;
    len_ch = CHW'(ch);
    len_val = (CODEBITS+1)'(val);
    next_cycle();
    len_we = 1'b0;
    len_m[ch] = (val < 2) ? 2 : val;
  endtask

  task automatic test_reset();
    logic [CHANS-1:0] m;
    int first;
    rst = 1'b1;
    full_chip = '1;
    for (int c = 0; c < CHANS; c++) begin
      nchip_m[c] = 0;
      len_m[c] = DEF_LEN;
    end
    drive_nchip();
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    checks += 4;
    if (code_o !== '0)  begin errors++; $display("FAIL reset_code: got %h expected 0", code_o); end
    if (epoch_o !== '0) begin errors++; $display("FAIL reset_epoch: got %h expected 0", epoch_o); end
    if (vld_o !== '0)   begin errors++; $display("FAIL reset_vld: got %h expected 0", vld_o); end
    if (wr_cnt !== '0)  begin errors++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
    full_chip = '0;
    for (int t = 1; t <= CHANS + RD_LAT + 1; t++) begin
      next_cycle();
      #1;
      m = '0;
      for (int c = 0; c < CHANS; c++) begin
        first = (c >= RD_LAT + 1) ? c : c + CHANS;
        if (t >= first) m[c] = 1'b1;
      end
      checks++;
      if (vld_o !== m) begin errors++; $display("FAIL vld_rise t=%0d: got %h expected %h", t, vld_o, m); end
    end
  endtask

  task automatic test_load();
    // Partial load of inverted data, then a rewind and the real load over it.
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      ld_start = (i == 0);
      wr = 1'b1;
      wr_data = ~code_tab[i];
    end
    next_cycle();
    ld_start = 1'b0; wr = 1'b0;
    #1;
    checks++;
    if (wr_cnt !== 13'd100) begin errors++; $display("FAIL wr_cnt_partial: got %0d expected 100", wr_cnt); end
    ld_start = 1'b1;
    next_cycle();
    ld_start = 1'b0;
    #1;
    checks++;
    if (wr_cnt !== 13'd0) begin errors++; $display("FAIL wr_cnt_rewind: got %0d expected 0", wr_cnt); end
    for (int i = 0; i < DEF_LEN; i++) begin
      next_cycle();
      ld_start = (i == 0);
      wr = 1'b1;
      wr_data = code_tab[i];
    end
    next_cycle();
    ld_start = 1'b0; wr = 1'b0;
    #1;
    checks++;
    if (wr_cnt !== 13'd4092) begin errors++; $display("FAIL wr_cnt_full: got %0d expected 4092", wr_cnt); end
    for (int i = DEF_LEN; i < DEPTH; i++) begin
      next_cycle();
      wr = 1'b1;
      wr_data = code_tab[i];
    end
    next_cycle();
    wr = 1'b0;
    #1;
    checks++;
    if (wr_cnt !== 13'd4096) begin errors++; $display("FAIL wr_cnt_depth: got %0d expected 4096", wr_cnt); end
    // One more write wraps to address 0; it rewrites the same word and the count saturates.
    wr = 1'b1;
    wr_data = code_tab[0];
    next_cycle();
    wr = 1'b0;
    #1;
    checks++;
    if (wr_cnt !== 13'd4096) begin errors++; $display("FAIL wr_cnt_sat: got %0d expected 4096", wr_cnt); end
  endtask

  // Steps every channel once per CHANS clocks at its phase and checks every output each clock.
  task automatic test_run(input int ncyc);
    int start;
    int nxt [CHANS];
    logic [CHANS-1:0] fc, pend, stepped;
    pend = '0;
    stepped = '0;
    for (int c = 0; c < CHANS; c++) begin
      ep_exp[c] = 0;
      ep_seen[c] = 0;
      nxt[c] = 0;
    end
    full_chip = '0;
    drive_nchip();
    start = cyc;
    for (int i = 0; i < ncyc; i++) begin
      next_cycle();
      for (int c = 0; c < CHANS; c++) begin
        if (pend[c]) begin nchip_m[c] = nxt[c]; pend[c] = 1'b0; end
      end
      drive_nchip();
      fc = '0;
      for (int c = 0; c < CHANS; c++) begin
        if (cyc >= start + SETTLE && ((cyc - c) % CHANS) == phase_m[c]) begin
          fc[c] = 1'b1;
          nxt[c] = (nchip_m[c] >= len_m[c] - 1) ? 0 : nchip_m[c] + 1;
          pend[c] = 1'b1;
          if (nxt[c] == 0) ep_exp[c]++;
        end
      end
      full_chip = fc;
      #1;
      for (int c = 0; c < CHANS; c++) begin
        if (epoch_o[c]) ep_seen[c]++;
        if (fc[c]) begin
          checks += 2;
          if (code_o[c] !== code_tab[nxt[c]][c]) begin
            errors++;
            $display("FAIL chip_code ch%0d cyc%0d chip%0d: got %b expected %b", c, cyc, nxt[c], code_o[c], code_tab[nxt[c]][c]);
          end
          if (epoch_o[c] !== (nxt[c] == 0)) begin
            errors++;
            $display("FAIL chip_epoch ch%0d cyc%0d chip%0d: got %b expected %b", c, cyc, nxt[c], epoch_o[c], (nxt[c] == 0));
          end
          stepped[c] = 1'b1;
        end else begin
          checks++;
          if (epoch_o[c] !== 1'b0) begin
            errors++;
            $display("FAIL idle_epoch ch%0d cyc%0d: got %b expected 0", c, cyc, epoch_o[c]);
          end
          if (stepped[c]) begin
            checks++;
            if (code_o[c] !== code_tab[nchip_m[c]][c]) begin
              errors++;
              $display("FAIL hold_code ch%0d cyc%0d chip%0d: got %b expected %b", c, cyc, nchip_m[c], code_o[c], code_tab[nchip_m[c]][c]);
            end
          end
        end
      end
    end
    next_cycle();
    full_chip = '0;
    for (int c = 0; c < CHANS; c++) if (pend[c]) nchip_m[c] = nxt[c];
    drive_nchip();
  endtask

  task automatic test_stepping();
    randomize_channels();
    test_run(10100);
    for (int c = 0; c < CHANS; c++) begin
      checks++;
      if (ep_seen[c] !== ep_exp[c]) begin
        errors++;
        $display("FAIL epoch_count ch%0d: got %0d expected %0d", c, ep_seen[c], ep_exp[c]);
      end
    end
  endtask

  task automatic test_wrap_ch3();
    randomize_channels();
    nchip_m[3] = 4088;
    test_run(SETTLE + 6*CHANS);
    checks++;
    if (ep_seen[3] !== 1) begin errors++; $display("FAIL wrap_ch3_epochs: got %0d expected 1", ep_seen[3]); end
  endtask

  task automatic test_lengths();
    set_len(5, 2046);
    set_len(7, 1);
    set_len(6, 100);
    randomize_channels();
    nchip_m[5] = 2042;
    nchip_m[7] = 0;
    nchip_m[6] = 3000;
    test_run(SETTLE + 6*CHANS);
    checks += 3;
    if (ep_seen[5] !== 1) begin errors++; $display("FAIL len2046_epochs: got %0d expected 1", ep_seen[5]); end
    if (ep_seen[6] !== 1) begin errors++; $display("FAIL stale_wrap_epochs: got %0d expected 1", ep_seen[6]); end
    if (ep_seen[7] !== 3) begin errors++; $display("FAIL len_clamp_epochs: got %0d expected 3", ep_seen[7]); end
  endtask

  task automatic test_reset_midrun();
    logic [CHANS-1:0] m;
    int first;
    randomize_channels();
    test_run(60);
    rst = 1'b1;
    full_chip = '1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks += 3;
    if (code_o !== '0)  begin errors++; $display("FAIL midrst_code: got %h expected 0", code_o); end
    if (epoch_o !== '0) begin errors++; $display("FAIL midrst_epoch: got %h expected 0", epoch_o); end
    if (vld_o !== '0)   begin errors++; $display("FAIL midrst_vld: got %h expected 0", vld_o); end
    full_chip = '0;
    for (int c = 0; c < CHANS; c++) len_m[c] = DEF_LEN;
    for (int t = 1; t <= CHANS + RD_LAT + 1; t++) begin
      next_cycle();
      #1;
      m = '0;
      for (int c = 0; c < CHANS; c++) begin
        first = (c >= RD_LAT + 1) ? c : c + CHANS;
        if (t >= first) m[c] = 1'b1;
      end
      checks++;
      if (vld_o !== m) begin errors++; $display("FAIL midrst_vld_rise t=%0d: got %h expected %h", t, vld_o, m); end
    end
    randomize_channels();
    test_run(400);
    for (int c = 0; c < CHANS; c++) begin
      checks++;
      if (ep_seen[c] !== ep_exp[c]) begin
        errors++;
        $display("FAIL midrst_epoch_count ch%0d: got %0d expected %0d", c, ep_seen[c], ep_exp[c]);
      end
    end
  endtask

  initial begin
    build_tab();
    test_reset();
    test_load();
    test_stepping();
    test_wrap_ch3();
    test_lengths();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnss_code_mem.md
# gnss_code_mem

Shared memory-code generator for the GPS/Galileo correlator bank. Holds one memory-resident spreading code per channel in a single dual-port BRAM, one bit column per channel. Per-channel programmable code lengths allow E1B (4092), B1I (2046) and test codes to coexist. A round-robin prefetch scheduler serves all channels from one read port, delivering each channel's next chip before that channel's `full_chip` strobe, plus an epoch flag on code wrap.

## Interface
- `CHANS`, 12: channel count; equals BRAM data width; must be > `RD_LAT`+1.
- `CODEBITS`, 12: chip index width; memory depth 2^`CODEBITS`.
- `RD_LAT`, 1: BRAM read latency in clocks (1 or 2).
- `DEF_LEN`, 4092: per-channel code length after reset.

- `clk`, in, 1: clock.
- `rst`, in, 1: reset `rst`, synchronous, active-high; clock `clk`.
- `ld_start`, in, 1: rewind write address to 0.
- `wr`, in, 1: write `wr_data` at write address, then post-increment.
- `wr_data`, in, `CHANS`: one chip for every channel column.
- `wr_cnt`, out, `CODEBITS`+1: words written since last `ld_start`/reset.
- `len_we`, in, 1: load code length for channel `len_ch`.
- `len_ch`, in, clog2(`CHANS`): channel select.
- `len_val`, in, `CODEBITS`+1: code length in chips, 2..2^`CODEBITS`.
- `nchip_n`, in, `CHANS`*`CODEBITS`: packed current chip index per channel (channel c at bits c*`CODEBITS` upward).
- `full_chip`, in, `CHANS`: chip-boundary strobe per channel.
- `code_o`, out, `CHANS`: current code bit per channel.
- `epoch_o`, out, `CHANS`: high with `full_chip[c]` when the new chip is chip 0.
- `vld_o`, out, `CHANS`: channel has had at least one completed prefetch since reset.

## Operation
- Write side: `waddr` resets to 0; `ld_start` forces 0 (priority over `wr` same cycle; that write goes to address 0 and `waddr` becomes 1). `waddr` wraps at 2^`CODEBITS`. `wr_cnt` saturates at 2^`CODEBITS`.
- Length registers `len_m1[c]` = `len_val`−1; reset to `DEF_LEN`−1. Values below 2 are clamped to 2.
- Scheduler: slot counter `ch_p` cycles 0..`CHANS`−1 every clock; counter is held at 0 during reset.
  - In slot `ch_p` it issues a read for channel k = (`ch_p`+`RD_LAT`+1) mod `CHANS`.
  - Address is `nchip[k]`+1, or 0 if `nchip[k]` ≥ `len_m1[k]`. This wrap compare uses ≥, so stale out-of-range indices also wrap.
  - The `wrap` bit for k is carried down the pipe with the read.
  - Read data bit k is captured into `next_bit[k]`/`next_wrap[k]` exactly when the read returns, which is the cycle `ch_p` == k again.
  - Each channel is therefore refreshed once every `CHANS` clocks.
- Consumer, per channel:
  - `code_o[c]` = `full_chip[c]` ? `next_bit[c]` : `cur_bit[c]`.
  - On `full_chip[c]`, `cur_bit[c]` <= `next_bit[c]`.
  - `epoch_o[c]` = `full_chip[c]` & `next_wrap[c]`, combinational.
- Read/write collision: the read returns the old data. Reloading a code while its channel runs is undefined. Rewriting other columns is not possible, since writes cover all columns.

## Timing
- Reset values: `waddr`=0, `wr_cnt`=0, `ch_p`=0, all `cur_bit`/`next_bit`/`next_wrap`/`vld_o`=0.
  - Hence `code_o`=0 and `epoch_o`=0 after reset regardless of `full_chip`.
  - A reset mid-load or mid-run discards in-flight reads; memory contents are kept.
- Prefetch staleness: `nchip[k]` is sampled `RD_LAT`+1 clocks before capture.
  - Caller contract: `full_chip[c]` at most once per `CHANS` clocks.
  - Caller contract: `nchip[c]` updates on the clock after `full_chip[c]`.
- Worst-case age of `next_bit[c]` is `CHANS` clocks. `code_o` change is zero-latency (combinational) relative to `full_chip`.
- `vld_o[c]` rises at the first capture slot of c after reset release: no later than `CHANS`+`RD_LAT`+1 clocks.
- `len_we` takes effect on the next scheduler read for that channel.

## Structure
- `CHANS`, `CODEBITS` and default lengths come from the generated kiwi config header, alongside the existing GPS constants.
- Keep `clog2` there.
- BRAM: reuse the 4k×`CHANS` simple dual-port ipcore; `RD_LAT` must match its output-register setting.
- One sub-module `code_hold`, instantiated per channel: `next_bit`/`cur_bit`/`next_wrap` registers, the `code_o` mux and `epoch_o`.

## Test plan
- Reset then load 4092 words where column c = LFSR_c(n); `ld_start` mid-load at word 100 -> `wr_cnt` restarts at 0 and reload from 0 is correct; final `wr_cnt`=4092.
- All 12 channels stepping every 12 clocks from random phases -> `code_o[c]` equals LFSR_c(`nchip`) on every chip, zero mismatches over 10k chips.
- Channel 3 at `nchip`=4091, `full_chip` -> `code_o[3]`=chip 0 bit and `epoch_o[3]`=1 for that cycle only.
- `len_we` ch 5 `len_val`=2046 -> wrap after 2045 with epoch; `len_val`=1 clamps to 2.
- `RD_LAT`=2 build, `CHANS`=4: same correctness checks pass; `vld_o` all high by clock 7 after reset.
- Assert `rst` mid-run -> `code_o`/`epoch_o`/`vld_o` = 0 next clock; resumed channels correct without reloading memory.
